// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Holds the FSM encoding, the default starvation limit and the register address width.
package rf_wb_arbiter_pkg;
  localparam int AW               = 5;
  localparam int DW               = 32;
  localparam int NREG             = 1 << AW;
  localparam int CW               = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_FORCE  = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy bit per architectural register: set on MDU issue, cleared on MDU write-back.
// Queries are masked for r0 and for a same-cycle write-back, which the regfile bypass covers.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_set_vld,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_vld,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_chk_addr1,
  input  logic [AW-1:0] i_chk_addr2,
  output logic          o_busy1,
  output logic          o_busy2
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_set_vld && i_set_addr != '0) w_set[i_set_addr] = 1'b1;
    if (i_clr_vld)                     w_clr[i_clr_addr] = 1'b1;
  end

  // OR-ing the set after the clear lets a same-cycle issue win over a retire.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign o_busy1 = r_busy[i_chk_addr1] && (i_chk_addr1 != '0) &&
                   !(i_clr_vld && i_clr_addr == i_chk_addr1);
  assign o_busy2 = r_busy[i_chk_addr2] && (i_chk_addr2 != '0) &&
                   !(i_clr_vld && i_clr_addr == i_chk_addr2);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and the MDU.
// A starving MDU forces a slot; a colliding pipe write parks in a 1-entry skid and drains next.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          mdu_valid,
  input  logic [AW-1:0] mdu_waddr,
  input  logic [DW-1:0] mdu_wdata,
  output logic          mdu_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] chk_raddr1,
  input  logic [AW-1:0] chk_raddr2,
  output logic          chk_busy1,
  output logic          chk_busy2,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);
  state_e        r_state;
  logic [CW-1:0] r_starve;
  logic          r_skid_vld;
  wr_t           r_skid;
  logic          r_post_rst;

  logic          w_pipe_req;
  logic          w_hold;
  logic          w_rdy;
  logic          w_stall;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_cap;
  logic          w_lose;

  assign w_pipe_req = pipe_we && (pipe_waddr != '0);
  assign w_hold     = rst || r_post_rst;

  always_comb begin
    w_rdy   = 1'b0;
    w_stall = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_cap   = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (w_pipe_req) begin
          w_we   = 1'b1;
          w_addr = pipe_waddr;
          w_data = pipe_wdata;
        end else if (mdu_valid) begin
          w_rdy  = 1'b1;
          w_we   = (mdu_waddr != '0);
          w_addr = mdu_waddr;
          w_data = mdu_wdata;
        end
      end
      ST_FORCE: begin
        w_stall = 1'b1;
        if (mdu_valid) begin
          w_rdy  = 1'b1;
          w_we   = (mdu_waddr != '0);
          w_addr = mdu_waddr;
          w_data = mdu_wdata;
          w_cap  = w_pipe_req;
        end
      end
      ST_DRAIN: begin
        w_stall = 1'b1;
        w_we    = r_skid_vld;
        w_addr  = r_skid.addr;
        w_data  = r_skid.data;
      end
      default: ;
    endcase
    // Nothing leaves the block during reset or the first cycle after it.
    if (w_hold) begin
      w_rdy   = 1'b0;
      w_stall = 1'b0;
      w_we    = 1'b0;
      w_cap   = 1'b0;
    end
  end

  assign w_lose = mdu_valid && !w_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_NORMAL;
      r_starve   <= '0;
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
      r_post_rst <= 1'b1;
    end else begin
      r_post_rst <= 1'b0;
      if (w_lose) r_starve <= (r_starve == '1) ? r_starve : r_starve + 1'b1;
      else        r_starve <= '0;
      case (r_state)
        ST_NORMAL: begin
          // >= rather than == so a count left over from DRAIN can never skip the force.
          if (w_lose && r_starve >= CW'(STARVE_LIMIT - 1)) r_state <= ST_FORCE;
        end
        ST_FORCE: begin
          if (w_cap) begin
            r_skid_vld <= 1'b1;
            r_skid     <= '{addr: pipe_waddr, data: pipe_wdata};
            r_state    <= ST_DRAIN;
          end else begin
            r_state    <= ST_NORMAL;
          end
        end
        ST_DRAIN: begin
          r_skid_vld <= 1'b0;
          r_state    <= ST_NORMAL;
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  rf_scoreboard u_sb (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_set_vld   (iss_valid),
    .i_set_addr  (iss_rd),
    .i_clr_vld   (mdu_valid && w_rdy),
    .i_clr_addr  (mdu_waddr),
    .i_chk_addr1 (chk_raddr1),
    .i_chk_addr2 (chk_raddr2),
    .o_busy1     (chk_busy1),
    .o_busy2     (chk_busy2)
  );

  assign mdu_ready = w_rdy;
  assign stall     = w_stall;
  assign rf_we     = w_we;
  assign rf_waddr  = w_addr;
  assign rf_wdata  = w_data;
endmodule
